// File: rtl/frame_buffer_pkg.sv
// Shared panel definitions for the double-buffered HUB75-style frame buffer.
// Holds the panel geometry defaults, the swap-FSM encoding and the BCM compare helper.
package frame_buffer_pkg;

    localparam int unsigned FB_WIDTH  = 64;
    localparam int unsigned FB_HEIGHT = 64;
    localparam int unsigned FB_BPC    = 4;
    localparam int unsigned CMP_W     = FB_BPC;

    typedef enum logic {
        StIdle    = 1'b0,
        StPending = 1'b1
    } swap_state_e;

    // Bit-reversed subframe index spreads each channel's on-time evenly across the frame.
    function automatic logic [CMP_W-1:0] bit_rev(input logic [CMP_W-1:0] v);
        logic [CMP_W-1:0] r;
        for (int i = 0; i < CMP_W; i++) begin
            r[i] = v[CMP_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_buffer_if.sv
// Writer and scan-driver signals of the frame buffer, bundled with master/slave views.
interface frame_buffer_if
    import frame_buffer_pkg::*;
#(
    parameter int unsigned WIDTH  = FB_WIDTH,
    parameter int unsigned HEIGHT = FB_HEIGHT,
    parameter int unsigned BPC    = FB_BPC
);
    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);

    logic              wr_valid;
    logic              wr_ready;
    logic [XW-1:0]     wr_x;
    logic [YW-1:0]     wr_y;
    logic [3*BPC-1:0]  wr_rgb;
    logic              wr_swap;
    logic              swap_done;
    logic              frame_start;
    logic              rd_en;
    logic [XW-1:0]     rd_x;
    logic [YW-2:0]     rd_addr;
    logic [CMP_W-1:0]  rd_subframe;
    logic              rd_valid;
    logic [2:0]        rd_rgb0;
    logic [2:0]        rd_rgb1;

    modport master (
        output wr_valid, wr_x, wr_y, wr_rgb, wr_swap, frame_start,
        output rd_en, rd_x, rd_addr, rd_subframe,
        input  wr_ready, swap_done, rd_valid, rd_rgb0, rd_rgb1
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_rgb, wr_swap, frame_start,
        input  rd_en, rd_x, rd_addr, rd_subframe,
        output wr_ready, swap_done, rd_valid, rd_rgb0, rd_rgb1
    );

endinterface

// File: rtl/fb_bank_ram.sv
// Simple dual-port RAM with registered read and no output reset, so it maps onto iCE40 EBR.
module fb_bank_ram #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 12
) (
    input  logic          clk30,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    localparam int unsigned Depth = 1 << AW;

    logic [DW-1:0] r_mem [Depth];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk30) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered panel frame store: writer fills the back buffer, scan driver reads the front
// buffer as BCM on/off bits; buffers swap only on a refresh-frame boundary.
module frame_buffer
    import frame_buffer_pkg::*;
#(
    parameter int unsigned WIDTH  = FB_WIDTH,
    parameter int unsigned HEIGHT = FB_HEIGHT,
    parameter int unsigned BPC    = FB_BPC
) (
    input  logic           clk30,
    input  logic           reset,
    frame_buffer_if.slave  fb
);
    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam int unsigned AW = XW + YW - 1;
    localparam int unsigned DW = 3 * BPC;

    swap_state_e      r_state;
    logic             r_front;
    logic             r_swap_done;
    logic             r_wr_ready;

    logic             r_vld_p1;
    logic             r_buf_p1;
    logic [CMP_W-1:0] r_cmp_p1;
    logic             r_rd_valid;
    logic [2:0]       r_rgb0;
    logic [2:0]       r_rgb1;

    logic             w_wr_fire;
    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    w_rd_addr;
    logic [DW-1:0]    w_rdata [2][2];
    logic [DW-1:0]    w_pix0;
    logic [DW-1:0]    w_pix1;
    logic [2:0]       w_bits0;
    logic [2:0]       w_bits1;

    always_ff @(posedge clk30) begin
        if (reset) begin
            r_state     <= StIdle;
            r_front     <= 1'b0;
            r_swap_done <= 1'b0;
            r_wr_ready  <= 1'b1;
        end else begin
            r_swap_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (fb.wr_swap && fb.frame_start) begin
                        r_front     <= ~r_front;
                        r_swap_done <= 1'b1;
                    end else if (fb.wr_swap) begin
                        r_state    <= StPending;
                        r_wr_ready <= 1'b0;
                    end
                end
                StPending: begin
                    if (fb.frame_start) begin
                        r_front     <= ~r_front;
                        r_swap_done <= 1'b1;
                        r_state     <= StIdle;
                        r_wr_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    r_wr_ready <= 1'b1;
                end
            endcase
        end
    end

    assign w_wr_fire = fb.wr_valid & r_wr_ready & ~reset;
    assign w_wr_addr = {fb.wr_y[YW-2:0], fb.wr_x};
    assign w_rd_addr = {fb.rd_addr, fb.rd_x};

    // Buffer b is written only while it is the back buffer; bank h holds one panel half.
    for (genvar b = 0; b < 2; b++) begin : g_buf
        for (genvar h = 0; h < 2; h++) begin : g_bank
            logic w_we;
            assign w_we = w_wr_fire & (r_front != 1'(b)) & (fb.wr_y[YW-1] == 1'(h));

            fb_bank_ram #(
                .AW (AW),
                .DW (DW)
            ) u_ram (
                .clk30   (clk30),
                .i_we    (w_we),
                .i_waddr (w_wr_addr),
                .i_wdata (fb.wr_rgb),
                .i_re    (fb.rd_en),
                .i_raddr (w_rd_addr),
                .o_rdata (w_rdata[b][h])
            );
        end
    end

    // Buffer choice is captured with rd_en so in-flight reads survive a swap.
    always_ff @(posedge clk30) begin
        r_buf_p1 <= r_front;
        r_cmp_p1 <= bit_rev(fb.rd_subframe);
    end

    always_comb begin
        w_pix0  = r_buf_p1 ? w_rdata[1][0] : w_rdata[0][0];
        w_pix1  = r_buf_p1 ? w_rdata[1][1] : w_rdata[0][1];
        w_bits0 = {w_pix0[3*BPC-1:2*BPC] > r_cmp_p1,
                   w_pix0[2*BPC-1:BPC]   > r_cmp_p1,
                   w_pix0[BPC-1:0]       > r_cmp_p1};
        w_bits1 = {w_pix1[3*BPC-1:2*BPC] > r_cmp_p1,
                   w_pix1[2*BPC-1:BPC]   > r_cmp_p1,
                   w_pix1[BPC-1:0]       > r_cmp_p1};
    end

    always_ff @(posedge clk30) begin
        if (reset) begin
            r_vld_p1   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rgb0     <= 3'b000;
            r_rgb1     <= 3'b000;
        end else begin
            r_vld_p1   <= fb.rd_en;
            r_rd_valid <= r_vld_p1;
            r_rgb0     <= r_vld_p1 ? w_bits0 : 3'b000;
            r_rgb1     <= r_vld_p1 ? w_bits1 : 3'b000;
        end
    end

    assign fb.wr_ready  = r_wr_ready;
    assign fb.swap_done = r_swap_done;
    assign fb.rd_valid  = r_rd_valid;
    assign fb.rd_rgb0   = r_rgb0;
    assign fb.rd_rgb1   = r_rgb1;

endmodule

// File: tb/tb_frame_buffer.sv
// Self-checking bench for frame_buffer: fixed vectors, corner-case sequences and random traffic
// checked every cycle against a whole-frame array model of the two buffers.
module tb_frame_buffer;
    import frame_buffer_pkg::*;

    logic clk30 = 1'b0;
    logic reset = 1'b1;

    frame_buffer_if fb_if ();

    frame_buffer dut (
        .clk30 (clk30),
        .reset (reset),
        .fb    (fb_if)
    );

    always #5 clk30 = ~clk30;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: whole pixel arrays indexed [buffer][row 0..63][column].
    logic [11:0] m_mem [2][64][64];
    bit          m_vld [2][64][64];
    int          m_front   = 0;
    bit          m_pending = 0;
    bit          m_sd_next = 0;

    typedef struct {
        bit       v;
        bit       c0;
        bit       c1;
        logic [2:0] e0;
        logic [2:0] e1;
    } rd_exp_t;

    rd_exp_t pipe1, pipe2;
    bit      chk_en = 0;
    int      n_valid = 0;
    int      ones1 = 0;

    function automatic logic [2:0] exp_rgb(input logic [11:0] pix, input int sf);
        int c;
        c = ((sf & 1) << 3) | ((sf & 2) << 1) | ((sf & 4) >> 1) | ((sf & 8) >> 3);
        return {int'(pix[11:8]) > c, int'(pix[7:4]) > c, int'(pix[3:0]) > c};
    endfunction

    task automatic step();
        rd_exp_t nx;
        int x, a, sf;
        nx = '{default: 0};
        if (chk_en) check("wr_ready", fb_if.wr_ready, !m_pending);
        if (fb_if.rd_en && !reset) begin
            x  = int'(fb_if.rd_x);
            a  = int'(fb_if.rd_addr);
            sf = int'(fb_if.rd_subframe);
            nx.v  = 1;
            nx.c0 = m_vld[m_front][a][x];
            nx.c1 = m_vld[m_front][a + 32][x];
            nx.e0 = exp_rgb(m_mem[m_front][a][x], sf);
            nx.e1 = exp_rgb(m_mem[m_front][a + 32][x], sf);
        end
        if (reset) begin
            m_pending = 0;
            m_sd_next = 0;
            m_front   = 0;
        end else begin
            if (fb_if.wr_valid && !m_pending) begin
                m_mem[1 - m_front][fb_if.wr_y][fb_if.wr_x] = fb_if.wr_rgb;
                m_vld[1 - m_front][fb_if.wr_y][fb_if.wr_x] = 1;
            end
            m_sd_next = 0;
            if (!m_pending && fb_if.wr_swap && fb_if.frame_start) begin
                m_front   = 1 - m_front;
                m_sd_next = 1;
            end else if (!m_pending && fb_if.wr_swap) begin
                m_pending = 1;
            end else if (m_pending && fb_if.frame_start) begin
                m_front   = 1 - m_front;
                m_pending = 0;
                m_sd_next = 1;
            end
        end
        @(posedge clk30);
        #1;
        if (reset) begin
            pipe1.v = 0;
            pipe2.v = 0;
        end else begin
            pipe2 = pipe1;
            pipe1 = nx;
        end
        if (chk_en) begin
            check("rd_valid", fb_if.rd_valid, pipe2.v);
            check("swap_done", fb_if.swap_done, m_sd_next);
            if (pipe2.v && pipe2.c0) check("rd_rgb0", fb_if.rd_rgb0, pipe2.e0);
            if (pipe2.v && pipe2.c1) check("rd_rgb1", fb_if.rd_rgb1, pipe2.e1);
            if (fb_if.rd_valid) begin
                n_valid++;
                ones1 += int'(fb_if.rd_rgb1[0]);
            end
        end
    endtask

    task automatic wr_px(input int x, input int y, input logic [11:0] rgb);
        fb_if.wr_valid = 1'b1;
        fb_if.wr_x     = 6'(x);
        fb_if.wr_y     = 6'(y);
        fb_if.wr_rgb   = rgb;
        step();
        fb_if.wr_valid = 1'b0;
    endtask

    task automatic rd_px(input int x, input int a, input int sf);
        fb_if.rd_en       = 1'b1;
        fb_if.rd_x        = 6'(x);
        fb_if.rd_addr     = 5'(a);
        fb_if.rd_subframe = 4'(sf);
        step();
        fb_if.rd_en = 1'b0;
    endtask

    task automatic do_swap();
        fb_if.wr_swap = 1'b1;
        step();
        fb_if.wr_swap = 1'b0;
        step();
        fb_if.frame_start = 1'b1;
        step();
        fb_if.frame_start = 1'b0;
        step();
    endtask

    typedef struct {
        int         x;
        int         a;
        logic [11:0] top;
        logic [11:0] bot;
        int         sf;
        logic [2:0] e0;
        logic [2:0] e1;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int n0;
        tbl[0] = '{x: 5,  a: 3,  top: 12'hFFF, bot: 12'h000, sf: 0,  e0: 3'b111, e1: 3'b000};
        tbl[1] = '{x: 6,  a: 3,  top: 12'h008, bot: 12'h800, sf: 1,  e0: 3'b000, e1: 3'b000};
        tbl[2] = '{x: 7,  a: 3,  top: 12'h008, bot: 12'h800, sf: 8,  e0: 3'b001, e1: 3'b100};
        tbl[3] = '{x: 8,  a: 4,  top: 12'h0F0, bot: 12'h000, sf: 15, e0: 3'b000, e1: 3'b000};
        tbl[4] = '{x: 9,  a: 4,  top: 12'h0F0, bot: 12'h0FF, sf: 7,  e0: 3'b010, e1: 3'b011};
        tbl[5] = '{x: 10, a: 31, top: 12'h123, bot: 12'h5A0, sf: 0,  e0: 3'b111, e1: 3'b110};
        tbl[6] = '{x: 11, a: 31, top: 12'h123, bot: 12'h5A0, sf: 4,  e0: 3'b001, e1: 3'b110};
        tbl[7] = '{x: 63, a: 0,  top: 12'h001, bot: 12'hF00, sf: 2,  e0: 3'b000, e1: 3'b100};

        pipe1 = '{default: 0};
        pipe2 = '{default: 0};
        fb_if.wr_valid = 0; fb_if.wr_x = 0; fb_if.wr_y = 0; fb_if.wr_rgb = 0;
        fb_if.wr_swap = 0; fb_if.frame_start = 0;
        fb_if.rd_en = 0; fb_if.rd_x = 0; fb_if.rd_addr = 0; fb_if.rd_subframe = 0;

        repeat (3) step();
        chk_en = 1;
        check("reset_rd_valid", fb_if.rd_valid, 0);
        check("reset_rgb0", fb_if.rd_rgb0, 0);
        check("reset_rgb1", fb_if.rd_rgb1, 0);
        check("reset_swap_done", fb_if.swap_done, 0);
        check("reset_wr_ready", fb_if.wr_ready, 1);
        reset = 1'b0;
        step();

        // Fixed vectors: write all, swap once, read each back after two cycles.
        for (int i = 0; i < 8; i++) begin
            wr_px(tbl[i].x, tbl[i].a, tbl[i].top);
            wr_px(tbl[i].x, tbl[i].a + 32, tbl[i].bot);
        end
        wr_px(20, 35, 12'h008);
        do_swap();
        for (int i = 0; i < 8; i++) begin
            rd_px(tbl[i].x, tbl[i].a, tbl[i].sf);
            step();
            check("tbl_valid", fb_if.rd_valid, 1);
            check("tbl_rgb0", fb_if.rd_rgb0, tbl[i].e0);
            check("tbl_rgb1", fb_if.rd_rgb1, tbl[i].e1);
        end

        // R=8 in the lower half is lit in exactly half of the subframes.
        step(); step();
        ones1 = 0;
        fb_if.rd_en = 1'b1; fb_if.rd_x = 6'd20; fb_if.rd_addr = 5'd3;
        for (int sf = 0; sf < 16; sf++) begin
            fb_if.rd_subframe = 4'(sf);
            step();
        end
        fb_if.rd_en = 1'b0;
        step(); step();
        check("sf_sweep_count", ones1, 8);

        // Long pending swap: writer stalled, front unchanged, repeated wr_swap ignored.
        wr_px(30, 3, 12'hFFF);
        do_swap();
        wr_px(30, 3, 12'h000);
        wr_px(31, 3, 12'hFFF);
        fb_if.wr_swap = 1'b1;
        step();
        fb_if.wr_swap = 1'b0;
        for (int i = 0; i < 100; i++) begin
            fb_if.wr_valid = (i % 3 == 0);
            fb_if.wr_x = 6'd31; fb_if.wr_y = 6'd3; fb_if.wr_rgb = 12'h000;
            fb_if.wr_swap = (i == 50);
            fb_if.rd_en = 1'b1; fb_if.rd_x = 6'd30; fb_if.rd_addr = 5'd3; fb_if.rd_subframe = 0;
            step();
            check("pend_wr_ready", fb_if.wr_ready, 0);
            if (i >= 2) check("pend_front_data", fb_if.rd_rgb0, 3'b111);
        end
        fb_if.wr_valid = 0; fb_if.wr_swap = 0; fb_if.rd_en = 0;
        fb_if.frame_start = 1'b1;
        step();
        fb_if.frame_start = 1'b0;
        check("pend_swap_done", fb_if.swap_done, 1);
        check("pend_ready_back", fb_if.wr_ready, 1);
        step();
        check("pend_swap_done_clear", fb_if.swap_done, 0);
        rd_px(30, 3, 0);
        step();
        check("post_swap_new", fb_if.rd_rgb0, 3'b000);
        rd_px(31, 3, 0);
        step();
        check("pend_write_dropped", fb_if.rd_rgb0, 3'b111);

        // Swap and frame_start together from idle.
        wr_px(32, 3, 12'h00F);
        do_swap();
        wr_px(32, 3, 12'h0F0);
        fb_if.wr_swap = 1'b1; fb_if.frame_start = 1'b1;
        fb_if.rd_en = 1'b1; fb_if.rd_x = 6'd32; fb_if.rd_addr = 5'd3; fb_if.rd_subframe = 0;
        step();
        fb_if.wr_swap = 0; fb_if.frame_start = 0; fb_if.rd_en = 0;
        check("same_cyc_swap_done", fb_if.swap_done, 1);
        step();
        check("same_cyc_old_data", fb_if.rd_rgb0, 3'b001);
        rd_px(32, 3, 0);
        step();
        check("same_cyc_new_data", fb_if.rd_rgb0, 3'b010);

        // Full-throughput streaming of one row.
        for (int x = 0; x < 64; x++) begin
            wr_px(x, 7, 12'($urandom));
            wr_px(x, 39, 12'($urandom));
        end
        do_swap();
        n0 = n_valid;
        fb_if.rd_en = 1'b1; fb_if.rd_addr = 5'd7;
        for (int x = 0; x < 64; x++) begin
            fb_if.rd_x = 6'(x);
            fb_if.rd_subframe = 4'($urandom);
            step();
        end
        fb_if.rd_en = 1'b0;
        step(); step();
        check("stream_valid_count", n_valid - n0, 64);

        // Reset while pending with reads in flight, then reset during a write.
        if (m_front == 0) do_swap();
        wr_px(41, 3, 12'h00F);
        do_swap();
        wr_px(40, 3, 12'hFFF);
        wr_px(41, 3, 12'h0F0);
        fb_if.wr_swap = 1'b1;
        step();
        fb_if.wr_swap = 1'b0;
        fb_if.rd_en = 1'b1; fb_if.rd_x = 6'd41; fb_if.rd_addr = 5'd3;
        step(); step();
        fb_if.rd_en = 1'b0;
        reset = 1'b1; fb_if.frame_start = 1'b1;
        step();
        reset = 1'b0; fb_if.frame_start = 1'b0;
        check("rst_rd_valid", fb_if.rd_valid, 0);
        check("rst_wr_ready", fb_if.wr_ready, 1);
        check("rst_swap_done", fb_if.swap_done, 0);
        rd_px(41, 3, 0);
        step();
        check("rst_front_kept", fb_if.rd_rgb0, 3'b001);
        reset = 1'b1;
        fb_if.wr_valid = 1'b1; fb_if.wr_x = 6'd40; fb_if.wr_y = 6'd3; fb_if.wr_rgb = 12'h000;
        step();
        reset = 1'b0; fb_if.wr_valid = 1'b0;
        do_swap();
        rd_px(40, 3, 0);
        step();
        check("rst_write_dropped", fb_if.rd_rgb0, 3'b111);

        // Random traffic on a small window so reads mostly hit written pixels.
        for (int i = 0; i < 1200; i++) begin
            fb_if.wr_valid    = $urandom_range(0, 1) == 1;
            fb_if.wr_x        = 6'($urandom_range(0, 15));
            fb_if.wr_y        = 6'($urandom_range(0, 3) + 32 * $urandom_range(0, 1));
            fb_if.wr_rgb      = 12'($urandom);
            fb_if.wr_swap     = $urandom_range(0, 63) == 0;
            fb_if.frame_start = $urandom_range(0, 15) == 0;
            fb_if.rd_en       = $urandom_range(0, 1) == 1;
            fb_if.rd_x        = 6'($urandom_range(0, 15));
            fb_if.rd_addr     = 5'($urandom_range(0, 3));
            fb_if.rd_subframe = 4'($urandom);
            step();
        end
        fb_if.wr_valid = 0; fb_if.wr_swap = 0; fb_if.frame_start = 0; fb_if.rd_en = 0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_buffer.md
FRAME_BUFFER -- requirements
Module: frame_buffer

Interface
REQ-001 Parameter WIDTH, default 64, panel columns; x is log2(WIDTH)=6 bits.
REQ-002 Parameter HEIGHT, default 64, panel rows; upper/lower halves scanned together, row address 5 bits.
REQ-003 Parameter BPC, default 4, bits per colour channel; pixel word is 3*BPC=12 bits {B,G,R}.
REQ-004 clk30  in  1  system clock.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 wr_valid  in  1  writer presents a pixel.
REQ-007 wr_ready  out  1  pixel accepted when wr_valid & wr_ready.
REQ-008 wr_x  in  6  pixel column.
REQ-009 wr_y  in  6  pixel row; wr_y[5] selects the lower-half bank.
REQ-010 wr_rgb  in  12  pixel colour {B[3:0],G[3:0],R[3:0]}.
REQ-011 wr_swap  in  1  one-cycle pulse: back buffer complete, request swap.
REQ-012 swap_done  out  1  one-cycle pulse when the swap takes effect.
REQ-013 frame_start  in  1  one-cycle pulse from the scan driver at start of a refresh frame (row address wraps to 0).
REQ-014 rd_en  in  1  scan driver requests the pixel pair at (rd_x, rd_addr).
REQ-015 rd_x  in  6  column being shifted.
REQ-016 rd_addr  in  5  row address; reads rows {0,rd_addr} and {1,rd_addr}.
REQ-017 rd_subframe  in  4  BCM subframe index.
REQ-018 rd_valid  out  1  rd_rgb0/rd_rgb1 valid.
REQ-019 rd_rgb0  out  3  {B,G,R} on/off bits, upper-half pixel.
REQ-020 rd_rgb1  out  3  {B,G,R} on/off bits, lower-half pixel.

Function
REQ-021 Storage: two buffers (front/back), each split into upper and lower banks of 2048x12; four RAMs total.
REQ-022 The accepted write goes to the back buffer, bank wr_y[5], address {wr_y[4:0],wr_x}.
REQ-023 The read takes both banks of the front buffer at address {rd_addr,rd_x} in the same cycle.
REQ-024 Read latency is exactly 2 cycles: rd_en in cycle N -> rd_valid=1 with data in cycle N+2; otherwise rd_valid=0.
REQ-025 rd_en must be accepted every cycle (full throughput, no backpressure on the read side).
REQ-026 Compare value cmp is bit-reversed rd_subframe ({sf[0],sf[1],sf[2],sf[3]}), sampled with rd_en.
REQ-027 Each channel bit = (channel value > cmp); value 0 is always off; value 15 is on in 15 of 16 subframes.
REQ-028 Swap control is two states. IDLE: wr_ready=1. PENDING: entered on wr_swap; wr_ready=0.
REQ-029 In PENDING, on frame_start: toggle the front select, pulse swap_done, return to IDLE.
REQ-030 wr_swap and frame_start in the same cycle from IDLE: swap applies that cycle; swap_done is next cycle.
REQ-031 A write handshaked in the same cycle as wr_swap completes to the old back buffer.
REQ-032 wr_swap while already PENDING is ignored; no double swap.
REQ-033 The front select changes only at frame_start, so a refresh frame never mixes buffers.
REQ-034 Reads already in flight when the swap occurs return data from the buffer sampled at rd_en.

Reset
REQ-035 Reset outputs: rd_valid=0, rd_rgb0=0, rd_rgb1=0, swap_done=0, wr_ready=1, state IDLE, front select=0.
REQ-036 Reset cancels in-flight reads and any pending swap; RAM contents are not cleared.
REQ-037 Reset asserted mid-write drops that write: no RAM write enable while reset=1.

Structure
REQ-038 WIDTH/HEIGHT/BPC defaults, the swap state encodings and the bit-reverse width go in the shared panel package.
REQ-039 One sub-module, fb_bank_ram: simple dual-port 2048x12, registered read, inferable as iCE40 EBR; instantiated four times.
REQ-040 The top level holds only the swap FSM, write/read address decode, pipeline registers and the comparator.

Verification
REQ-041 Write (x=5,y=3,rgb=0xFFF), swap, frame_start; rd_en x=5 addr=3 sf=0 -> rd_rgb0=3'b111 two cycles later, rd_rgb1=0.
REQ-042 Pixel R=8 at y=35; sweep sf 0..15 -> rd_rgb1[0]=1 in exactly 8 of 16 subframes.
REQ-043 wr_swap with no frame_start for 100 cycles -> wr_ready=0 throughout, front unchanged; then frame_start -> swap_done pulse, wr_ready=1 next cycle.
REQ-044 wr_swap and frame_start in the same cycle -> swap_done the next cycle; reads issued after it return new-buffer data.
REQ-045 rd_en held 64 consecutive cycles -> 64 consecutive rd_valid cycles, columns in order, 2-cycle latency.
REQ-046 Reset asserted in PENDING with reads in flight -> next cycle rd_valid=0, wr_ready=1; front select unchanged from before the reset.
